fwft_burst_reader: RTL and testbench
====================================

Name: fwft_burst_reader

Overview:
- Consumer/reader end of a first-word-fall-through FIFO read interface (ffrvld/ffrdata presented, ffrreq pops).
- Accepts a burst command (beat count), pops exactly that many words from the FIFO and forwards them on a registered valid/ready stream, tagging the final beat with m_last.
- Sits between NPU data FIFOs and downstream engines that consume fixed-length bursts.

Parameters:
- DW, 8, data width; must match the FIFO data width.
- BLW, 8, width of cmd_len; a burst is cmd_len+1 beats, so 1..2^BLW beats.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_vld  input  1  burst command valid.
- cmd_len  input  BLW  beats minus one.
- cmd_rdy  output  1  command accepted when cmd_vld & cmd_rdy.
- ffrvld  input  1  FIFO head word valid (FWFT).
- ffrdata  input  DW  FIFO head word.
- ffrreq  output  1  pop FIFO head this cycle.
- m_vld  output  1  output beat valid (registered).
- m_data  output  DW  output beat data (registered).
- m_last  output  1  final beat of the burst (registered).
- m_rdy  input  1  downstream ready.
- busy  output  1  a burst is in progress (state != IDLE).
- done  output  1  one-cycle pulse when the last beat transfers (m_vld & m_rdy & m_last).

Behaviour:
- Reset values: state=IDLE, m_vld=0, m_data=0, m_last=0, remaining=0, done=0. cmd_rdy=1 and ffrreq=0 follow from IDLE.
- remaining is a BLW+1-bit down-counter, loaded with cmd_len+1 so it does not overflow at the maximum length.
- FSM state IDLE:
  - cmd_rdy=1; ffrreq=0.
  - On cmd_vld: load remaining and go to BURST.
- FSM state BURST:
  - cmd_rdy=0.
  - Pop condition: ffrreq = ffrvld & (remaining!=0) & (~m_vld | m_rdy). This is combinational from ffrvld and m_rdy; the block has no internal buffering beyond the output register.
  - On a pop:
    - m_data <= ffrdata.
    - m_vld <= 1.
    - m_last <= (remaining==1).
    - remaining decrements.
  - If remaining==1 on the pop, go to DRAIN.
  - If m_vld & m_rdy with no pop: m_vld <= 0.
  - If ffrvld is low (FIFO empty): no pop. The output register empties normally and the block waits indefinitely.
- FSM state DRAIN:
  - ffrreq=0; cmd_rdy=0.
  - On m_vld & m_rdy (the m_last beat): m_vld <= 0, m_last <= 0, done pulses, go to IDLE.
- Hold rule: while m_vld & ~m_rdy, m_data and m_last are held stable and ffrreq=0.
- Throughput: one beat per cycle when ffrvld and m_rdy are continuously high.
- Latency: command accepted in cycle N → earliest pop in cycle N+1 → first m_vld in cycle N+2.
- Command turnaround: the next command is accepted the cycle after done. There are 2 idle cycles on m_vld between back-to-back bursts; this is acceptable.
- cmd_len=0: a single beat, with m_last set on that beat.
- No word is ever popped outside BURST, and never more than cmd_len+1 words per command.
- ffrdata is sampled only in a cycle where ffrreq=1.
- Reset mid-burst: all state clears immediately.
  - Words already popped are lost.
  - FIFO contents are untouched.
  - The upstream FIFO must be reset by the same reset.

Decomposition:
- Package fwft_burst_pkg holds the typedef enum logic [1:0] {IDLE, BURST, DRAIN} rd_state_e.
- No sub-module: the FSM, counter and output register belong in a single module.

Test Plan:
1. FIFO preloaded with 0x10..0x13, m_rdy=1, cmd_len=3 → m_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles starting 2 cycles after the command; m_last only on 0x13; 4 ffrreq pulses; done pulses once.
2. cmd_len=0 with FIFO holding 0xA5,0x5A → one beat 0xA5 with m_last=1; 0x5A remains in the FIFO (ffvcnt=1).
3. m_rdy toggled 1,0,0,1,… during an 8-beat burst → no beat is lost or duplicated; m_data is stable while stalled; ffrreq is never asserted while m_vld & ~m_rdy.
4. FIFO empty at command, words written one every 3 cycles, cmd_len=2 → 3 beats delivered in order; busy stays high throughout; no ffrreq while ffrvld=0.
5. cmd_len=255 (BLW=8), FIFO streaming continuously → exactly 256 beats, m_last on beat 256, counter does not wrap.
6. reset asserted after beat 2 of 5 → outputs go to reset values asynchronously; the next command after deassertion behaves as in scenario 1.

Source files
------------

// File: rtl/fwft_burst_pkg.sv
// fwft_burst_pkg
//   Shared types for the FWFT burst reader.
//   rd_state_e : reader FSM state encoding (IDLE, BURST, DRAIN).
package fwft_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fwft_burst_reader.sv
// fwft_burst_reader
//   Pops a commanded number of words from a first-word-fall-through FIFO and
//   forwards them on a registered valid/ready stream. The final beat of each
//   burst is tagged with m_last.
//
// Ports:
//   clk, reset         : clock (rising edge), asynchronous active-high reset
//   cmd_vld/cmd_len    : burst command, cmd_len+1 beats
//   cmd_rdy            : command accepted when cmd_vld & cmd_rdy
//   ffrvld/ffrdata     : FIFO head word (FWFT)
//   ffrreq             : pop FIFO head this cycle
//   m_vld/m_data/m_last: registered output beat
//   m_rdy              : downstream ready
//   busy               : a burst is in progress
//   done               : pulses while the m_last beat transfers
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; cmd_rdy high, no pops
// BURST | popping words while remaining != 0 and output register free
// DRAIN | all words popped; waiting for the m_last beat to transfer
module fwft_burst_reader
    import fwft_burst_pkg::*;
#(
    parameter int DW  = 8,
    parameter int BLW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_vld,
    input  logic [BLW-1:0] cmd_len,
    output logic           cmd_rdy,
    input  logic           ffrvld,
    input  logic [DW-1:0]  ffrdata,
    output logic           ffrreq,
    output logic           m_vld,
    output logic [DW-1:0]  m_data,
    output logic           m_last,
    input  logic           m_rdy,
    output logic           busy,
    output logic           done
);

    // One bit wider than cmd_len so a maximum-length burst does not wrap.
    localparam logic [BLW:0] ONE = {{BLW{1'b0}}, 1'b1};

    rd_state_e      state_q, state_d;
    logic [BLW:0]   remaining_q, remaining_d;
    logic           m_vld_q, m_vld_d;
    logic [DW-1:0]  m_data_q, m_data_d;
    logic           m_last_q, m_last_d;
    logic           out_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            m_vld_q     <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            m_vld_q     <= m_vld_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        m_vld_d     = m_vld_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        cmd_rdy     = 1'b0;
        ffrreq      = 1'b0;
        done        = 1'b0;
        // The output register is the only storage, so a pop is allowed only
        // when it is empty or being emptied this cycle.
        out_free    = ~m_vld_q | m_rdy;

        unique case (state_q)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_vld) begin
                    remaining_d = {1'b0, cmd_len} + ONE;
                    state_d     = BURST;
                end
            end
            BURST: begin
                ffrreq = ffrvld & (remaining_q != '0) & out_free;
                if (ffrreq) begin
                    m_data_d    = ffrdata;
                    m_vld_d     = 1'b1;
                    m_last_d    = (remaining_q == ONE);
                    remaining_d = remaining_q - ONE;
                    if (remaining_q == ONE) begin
                        state_d = DRAIN;
                    end
                end else if (m_vld_q && m_rdy) begin
                    m_vld_d = 1'b0;
                end
            end
            DRAIN: begin
                if (m_vld_q && m_rdy) begin
                    m_vld_d  = 1'b0;
                    m_last_d = 1'b0;
                    done     = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_vld  = m_vld_q;
    assign m_data = m_data_q;
    assign m_last = m_last_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fwft_burst_reader.sv
// tb_fwft_burst_reader
//   Drives fwft_burst_reader from a behavioural FWFT FIFO model. Each accepted
//   command pushes the indices of the words it must deliver (in FIFO write
//   order) into a scoreboard; an independent monitor pops and compares on
//   every output transfer and watches the pop/hold/busy rules each cycle.
module tb_fwft_burst_reader;

    localparam int DW  = 8;
    localparam int BLW = 8;

    logic           clk     = 1'b0;
    logic           reset   = 1'b1;
    logic           cmd_vld = 1'b0;
    logic [BLW-1:0] cmd_len = '0;
    logic           cmd_rdy;
    logic           ffrvld;
    logic [DW-1:0]  ffrdata;
    logic           ffrreq;
    logic           m_vld;
    logic [DW-1:0]  m_data;
    logic           m_last;
    logic           m_rdy   = 1'b1;
    logic           busy;
    logic           done;

    fwft_burst_reader #(.DW(DW), .BLW(BLW)) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd_vld (cmd_vld),
        .cmd_len (cmd_len),
        .cmd_rdy (cmd_rdy),
        .ffrvld  (ffrvld),
        .ffrdata (ffrdata),
        .ffrreq  (ffrreq),
        .m_vld   (m_vld),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_rdy   (m_rdy),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- FWFT FIFO model (shares the DUT reset) ----------------
    logic [DW-1:0] fmem [0:1023];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 0;
            rd_ptr <= 0;
        end else begin
            if (ffrreq) rd_ptr <= rd_ptr + 1;
            if (wr_en) begin
                fmem[wr_ptr[9:0]] <= wr_data;
                wr_ptr <= wr_ptr + 1;
            end
        end
    end
    assign ffrvld  = (wr_ptr != rd_ptr);
    assign ffrdata = fmem[rd_ptr[9:0]];

    // ---------------- FIFO writer ----------------
    logic [DW-1:0] to_write [$];
    logic [DW-1:0] wr_hist  [$];
    int            wr_mode = 0;   // 0 every cycle, 1 one per 3 cycles, 2 random
    int            wr_gap  = 0;

    initial begin : writer
        bit go;
        forever begin
            @(posedge clk); #1;
            wr_en = 1'b0;
            if (!reset && to_write.size() > 0) begin
                case (wr_mode)
                    0:       go = 1'b1;
                    1:       go = (wr_gap == 0);
                    default: go = ($urandom_range(1, 0) == 1);
                endcase
                wr_gap = (wr_gap + 1) % 3;
                if (go) begin
                    wr_data = to_write.pop_front();
                    wr_en   = 1'b1;
                    wr_hist.push_back(wr_data);
                end
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    int rdy_mode  = 0;   // 0 always, 1 pattern 1,0,0 repeating, 2 random
    int rdy_phase = 0;

    initial begin : rdy_drv
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_rdy = 1'b1;
                1: begin
                    m_rdy     = (rdy_phase == 0);
                    rdy_phase = (rdy_phase + 1) % 3;
                end
                default: m_rdy = ($urandom_range(1, 0) == 1);
            endcase
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q [$];
    exp_t e;
    int   next_word = 0;

    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            cur_n = 0, pop_cnt = 0, beat_cnt = 0;
    int            first_cyc = 0, done_cyc = 0, acc_cyc = 0;
    bit            lat_pend = 1'b0, lat_chk = 1'b0, first_pend = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            pop_cnt    = 0;
            lat_pend   = 1'b0;
            first_pend = 1'b0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (!(m_vld && m_data == prev_data && m_last == prev_last)) begin
                    n_err++;
                    $display("FAIL hold: got vld=%0b data=%h last=%0b, want vld=1 data=%h last=%0b",
                             m_vld, m_data, m_last, prev_data, prev_last);
                end
            end
            if (ffrreq) begin
                n_vec++;
                pop_cnt++;
                if (!ffrvld || !busy || (m_vld && !m_rdy)) begin
                    n_err++;
                    $display("FAIL pop_guard: ffrreq=1 with ffrvld=%0b busy=%0b m_vld=%0b m_rdy=%0b, want no pop",
                             ffrvld, busy, m_vld, m_rdy);
                end
            end
            if (exp_q.size() > 0) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy: got %0b with %0d beats outstanding, want 1", busy, exp_q.size());
                end
            end
            if (lat_pend && m_vld) begin
                lat_pend = 1'b0;
                if (lat_chk) begin
                    n_vec++;
                    if (cyc - acc_cyc != 2) begin
                        n_err++;
                        $display("FAIL latency: first m_vld %0d cycles after accept, want 2", cyc - acc_cyc);
                    end
                end
            end
            if (first_pend && m_vld) begin
                first_cyc  = cyc;
                first_pend = 1'b0;
            end
            if (m_vld && m_rdy) begin
                beat_cnt++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat: unexpected beat data=%h last=%0b, want none", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (e.idx >= wr_hist.size() || m_data !== wr_hist[e.idx] ||
                        m_last !== e.last || done !== e.last) begin
                        n_err++;
                        $display("FAIL beat: got data=%h last=%0b done=%0b, want data=%h last=%0b done=%0b",
                                 m_data, m_last, done,
                                 (e.idx < wr_hist.size()) ? wr_hist[e.idx] : 8'hxx, e.last, e.last);
                    end
                end
                if (m_last) begin
                    done_cyc = cyc;
                    n_vec++;
                    if (pop_cnt != cur_n) begin
                        n_err++;
                        $display("FAIL pop_count: got %0d pops, want %0d", pop_cnt, cur_n);
                    end
                end
            end else if (done) begin
                n_vec++;
                n_err++;
                $display("FAIL done: got pulse without last transfer, want 0");
            end
            if (cmd_vld && cmd_rdy) begin
                cur_n      = int'(cmd_len) + 1;
                pop_cnt    = 0;
                lat_pend   = 1'b1;
                lat_chk    = ffrvld;
                acc_cyc    = cyc;
                first_pend = 1'b1;
            end
            prev_stall = m_vld && !m_rdy;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic preload(input logic [DW-1:0] w);
        to_write.push_back(w);
    endtask

    task automatic wait_written(input int budget);
        int t = 0;
        while (to_write.size() > 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        if (to_write.size() > 0) chk("write_timeout", to_write.size(), 0);
    endtask

    task automatic send_cmd(input int len);
        int t = 0;
        @(posedge clk); #1;
        cmd_vld = 1'b1;
        cmd_len = len[BLW-1:0];
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_rdy && t < 200);
        if (!cmd_rdy) begin
            chk("cmd_accept", 0, 1);
            @(posedge clk); #1;
            cmd_vld = 1'b0;
        end else begin
            @(posedge clk); #1;
            cmd_vld = 1'b0;
            for (int i = 0; i <= len; i++) begin
                exp_q.push_back('{idx: next_word + i, last: (i == len)});
            end
            next_word += len + 1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((exp_q.size() > 0 || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0 || busy) chk("burst_timeout", exp_q.size(), 0);
    endtask

    task automatic burst_0x10();
        for (int i = 0; i < 4; i++) preload(8'h10 + i[7:0]);
        wait_written(50);
        send_cmd(3);
        wait_idle(100);
        chk("s1_throughput", done_cyc - first_cyc, 3);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : stim
        int b0;
        int t;
        int len;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_vld",   m_vld,   0);
        chk("rst_m_data",  m_data,  0);
        chk("rst_m_last",  m_last,  0);
        chk("rst_busy",    busy,    0);
        chk("rst_done",    done,    0);
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_ffrreq",  ffrreq,  0);
        reset = 1'b0;

        // 1: four-beat burst from a preloaded FIFO
        burst_0x10();

        // 2: single beat, second word stays behind
        preload(8'hA5);
        preload(8'h5A);
        wait_written(50);
        send_cmd(0);
        wait_idle(100);
        @(negedge clk);
        chk("s2_ffvcnt", wr_ptr - rd_ptr, 1);

        // 3: stalling downstream over an 8-beat burst (0x5A is the first word)
        rdy_mode  = 1;
        rdy_phase = 0;
        for (int i = 0; i < 7; i++) preload(8'($urandom));
        wait_written(50);
        send_cmd(7);
        wait_idle(300);
        rdy_mode = 0;

        // 4: empty FIFO at command, words trickle in
        @(negedge clk);
        chk("s4_empty", ffrvld, 0);
        send_cmd(2);
        wr_mode = 1;
        for (int i = 0; i < 3; i++) preload(8'hC0 + i[7:0]);
        wait_idle(200);
        wr_mode = 0;

        // 5: maximum length burst
        for (int i = 0; i < 256; i++) preload(i[7:0] ^ 8'h3C);
        wait_written(400);
        send_cmd(255);
        wait_idle(2000);
        chk("s5_throughput", done_cyc - first_cyc, 255);
        @(negedge clk);
        chk("s5_fifo_empty", wr_ptr - rd_ptr, 0);

        // 6: reset in the middle of a burst, then a clean burst
        for (int i = 0; i < 5; i++) preload(8'h60 + i[7:0]);
        wait_written(50);
        b0 = beat_cnt;
        send_cmd(4);
        t = 0;
        while (beat_cnt < b0 + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("s6_two_beats", beat_cnt - b0, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("s6_m_vld",   m_vld,   0);
        chk("s6_m_data",  m_data,  0);
        chk("s6_m_last",  m_last,  0);
        chk("s6_busy",    busy,    0);
        chk("s6_cmd_rdy", cmd_rdy, 1);
        chk("s6_ffrreq",  ffrreq,  0);
        exp_q.delete();
        next_word = wr_hist.size();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        burst_0x10();

        // random bursts with random FIFO fill and random back-pressure
        wr_mode  = 2;
        rdy_mode = 2;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(15, 0);
            for (int i = 0; i <= len; i++) preload(8'($urandom));
            send_cmd(len);
            wait_idle(1000);
        end
        wr_mode  = 0;
        rdy_mode = 0;

        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
